// File: rtl/weight_updater_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg -- shared types and constants for the weight-update datapath.
//   upd_state_t : FSM state encoding of weight_updater (IDLE/UPDATE/DONE).
//   SAT_MIN     : lower clamp of an unsigned weight.
//   sat_max()   : upper clamp of an unsigned weight of a given width.
// -----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } upd_state_t;

    localparam int SAT_MIN = 0;

    // Largest value representable by an unsigned weight of width bl.
    function automatic int sat_max(input int bl);
        return (1 << bl) - 1;
    endfunction

endpackage

// File: rtl/weight_updater_if.sv
// -----------------------------------------------------------------------------
// weight_updater_if -- control/data bundle between a training controller and
// the weight updater.
//   load_en, load_weights : bulk overwrite of the weight store
//   start_valid/ready     : update-request handshake
//   error, inputs         : error term and activations of the request
//   weights               : current weight store
//   busy, done            : FSM status
// master = controller side, slave = weight_updater side.
// -----------------------------------------------------------------------------
interface weight_updater_if #(
    parameter int num_inputs = 2,
    parameter int bit_length = 4
);
    logic                                  load_en;
    logic [num_inputs-1:0][bit_length-1:0] load_weights;
    logic                                  start_valid;
    logic                                  start_ready;
    logic signed [bit_length-1:0]          error;
    logic [num_inputs-1:0][bit_length-1:0] inputs;
    logic [num_inputs-1:0][bit_length-1:0] weights;
    logic                                  busy;
    logic                                  done;

    modport master (
        output load_en, load_weights, start_valid, error, inputs,
        input  start_ready, weights, busy, done
    );

    modport slave (
        input  load_en, load_weights, start_valid, error, inputs,
        output start_ready, weights, busy, done
    );
endinterface

// File: rtl/weight_updater_delta_sat.sv
// -----------------------------------------------------------------------------
// weight_delta_sat -- combinational single-weight update:
//   new_w = clamp(w + ((error * x) >>> lr_shift), 0, 2^bit_length-1)
// Ports:
//   w     : current unsigned weight
//   x     : unsigned activation paired with w
//   error : signed error term
//   new_w : saturated updated weight
// -----------------------------------------------------------------------------
module weight_delta_sat
    import nn_pkg::*;
#(
    parameter int bit_length = 4,
    parameter int lr_shift   = 2
) (
    input  logic [bit_length-1:0]        w,
    input  logic [bit_length-1:0]        x,
    input  logic signed [bit_length-1:0] error,
    output logic [bit_length-1:0]        new_w
);
    localparam int PW = 2 * bit_length + 1;  // product width
    localparam int SW = PW + 1;              // sum width, never overflows
    localparam logic signed [SW-1:0] SUM_MAX = SW'(sat_max(bit_length));
    localparam logic signed [SW-1:0] SUM_MIN = SW'(SAT_MIN);

    logic signed [PW-1:0] e_ext;
    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] delta;
    logic signed [SW-1:0] w_ext;
    logic signed [SW-1:0] d_ext;
    logic signed [SW-1:0] sum;

    // NOTE: every variable gets a value on every path through always_comb,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        e_ext = {{(PW-bit_length){error[bit_length-1]}}, error};
        x_ext = {{(PW-bit_length){1'b0}}, x};   // activation is unsigned
        prod  = e_ext * x_ext;
        delta = prod >>> lr_shift;              // floor division by 2^lr_shift
        w_ext = {{(SW-bit_length){1'b0}}, w};
        d_ext = {delta[PW-1], delta};
        sum   = w_ext + d_ext;
        new_w = sum[bit_length-1:0];
        if (sum < SUM_MIN) begin
            new_w = '0;
        end else if (sum > SUM_MAX) begin
            new_w = '1;
        end
    end
endmodule

// File: rtl/weight_updater.sv
// -----------------------------------------------------------------------------
// weight_updater -- sequential weight store with error-driven update.
// An accepted request captures error and inputs, then walks the weights one
// per cycle through a single shared weight_delta_sat, pulses done for one
// cycle and returns to IDLE. Weights can be bulk-loaded while idle.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : weight_updater_if slave (load, request handshake, weights, status)
// -----------------------------------------------------------------------------
module weight_updater
    import nn_pkg::*;
#(
    parameter int num_inputs = 2,
    parameter int bit_length = 4,
    parameter int lr_shift   = 2
) (
    input logic             clk,
    input logic             rst,
    weight_updater_if.slave bus
);
    localparam int IW = (num_inputs > 1) ? $clog2(num_inputs) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(num_inputs - 1);

    upd_state_t                            state;
    logic [IW-1:0]                         idx;
    logic signed [bit_length-1:0]          error_q;
    logic [num_inputs-1:0][bit_length-1:0] inputs_q;
    logic [num_inputs-1:0][bit_length-1:0] weights_q;
    logic                                  busy_q;
    logic                                  done_q;
    logic [bit_length-1:0]                 new_w;

    weight_delta_sat #(
        .bit_length (bit_length),
        .lr_shift   (lr_shift)
    ) u_delta_sat (
        .w     (weights_q[idx]),
        .x     (inputs_q[idx]),
        .error (error_q),
        .new_w (new_w)
    );

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the weight store is reset here because reset must abort
            // an update and leave a known all-zero store.
            state     <= IDLE;
            idx       <= '0;
            error_q   <= '0;
            inputs_q  <= '0;
            weights_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.load_en) begin
                        weights_q <= bus.load_weights;   // load beats start
                    end else if (bus.start_valid) begin
                        error_q  <= bus.error;
                        inputs_q <= bus.inputs;
                        idx      <= '0;
                        busy_q   <= 1'b1;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    weights_q[idx] <= new_w;
                    if (idx == LAST_IDX) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    idx    <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE) && !bus.load_en && !rst;
    assign bus.weights     = weights_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_weight_updater.sv
// -----------------------------------------------------------------------------
// tb_weight_updater -- directed self-checking bench for weight_updater
// (num_inputs=2, bit_length=4, lr_shift=2). Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_weight_updater;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    weight_updater_if #(.num_inputs(2), .bit_length(4)) bus ();

    weight_updater #(
        .num_inputs (2),
        .bit_length (4),
        .lr_shift   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] w0, input logic [3:0] w1);
        bus.load_weights[0] = w0;
        bus.load_weights[1] = w1;
        bus.load_en = 1'b1;
        tick();
        bus.load_en = 1'b0;
    endtask

    // Issues one request and waits (bounded) for done, ending back in IDLE.
    task automatic run_update(input logic signed [3:0] e,
                              input logic [3:0] x0, input logic [3:0] x1);
        bit seen_done = 1'b0;
        bus.error = e;
        bus.inputs[0] = x0;
        bus.inputs[1] = x1;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (seen_done !== 1'b1) begin
            n_bad++;
            $display("FAIL run_update_done: done not seen within 10 cycles (got %b, want 1)", seen_done);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.load_en = 1'b0;
        bus.load_weights = '0;
        bus.start_valid = 1'b0;
        bus.error = '0;
        bus.inputs = '0;
        tick();
        tick();
        n_cmp++;
        if (bus.weights !== 8'h00) begin
            n_bad++; $display("FAIL reset_weights: got %h want 00", bus.weights);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL reset_status: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        n_cmp++;
        if (bus.start_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready_in_rst: got %b want 0", bus.start_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.start_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready_after: got %b want 1", bus.start_ready);
        end
    endtask

    task automatic test_load();
        bus.load_weights[0] = 4'd5;
        bus.load_weights[1] = 4'd10;
        bus.load_en = 1'b1;
        #1;
        n_cmp++;
        if (bus.start_ready !== 1'b0) begin
            n_bad++; $display("FAIL load_ready_low: got %b want 0", bus.start_ready);
        end
        tick();
        bus.load_en = 1'b0;
        n_cmp++;
        if (bus.weights[0] !== 4'd5 || bus.weights[1] !== 4'd10) begin
            n_bad++; $display("FAIL load_weights: got %0d,%0d want 5,10", bus.weights[0], bus.weights[1]);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL load_status: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    // Cycle-exact latency check; inputs are scrambled after acceptance.
    task automatic test_update();
        load(4'd5, 4'd10);
        bus.error = 4'sd2;
        bus.inputs[0] = 4'd6;
        bus.inputs[1] = 4'd0;
        bus.start_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.start_ready !== 1'b1) begin
            n_bad++; $display("FAIL upd_ready: got %b want 1", bus.start_ready);
        end
        tick();                                  // edge T
        bus.start_valid = 1'b0;
        bus.error = 4'sd7;
        bus.inputs[0] = 4'd15;
        bus.inputs[1] = 4'd15;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.weights[0] !== 4'd5 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL upd_T: busy=%b w0=%0d done=%b want 1 5 0", bus.busy, bus.weights[0], bus.done);
        end
        tick();                                  // edge T+1
        n_cmp++;
        if (bus.weights[0] !== 4'd8 || bus.weights[1] !== 4'd10 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL upd_T1: w=%0d,%0d done=%b want 8,10 0", bus.weights[0], bus.weights[1], bus.done);
        end
        tick();                                  // edge T+2
        n_cmp++;
        if (bus.weights[1] !== 4'd10 || bus.done !== 1'b1 || bus.start_ready !== 1'b0) begin
            n_bad++; $display("FAIL upd_T2: w1=%0d done=%b ready=%b want 10 1 0", bus.weights[1], bus.done, bus.start_ready);
        end
        tick();                                  // edge T+3
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.start_ready !== 1'b1) begin
            n_bad++; $display("FAIL upd_T3: done=%b busy=%b ready=%b want 0 0 1", bus.done, bus.busy, bus.start_ready);
        end
    endtask

    task automatic test_saturation();
        load(4'd3, 4'd10);
        run_update(-4'sd3, 4'd5, 4'd0);          // -15>>>2 = -4, 3-4 -> 0
        n_cmp++;
        if (bus.weights[0] !== 4'd0 || bus.weights[1] !== 4'd10) begin
            n_bad++; $display("FAIL sat_low: got %0d,%0d want 0,10", bus.weights[0], bus.weights[1]);
        end
        run_update(4'sd7, 4'd0, 4'd15);          // 105>>>2 = 26, 10+26 -> 15
        n_cmp++;
        if (bus.weights[0] !== 4'd0 || bus.weights[1] !== 4'd15) begin
            n_bad++; $display("FAIL sat_high: got %0d,%0d want 0,15", bus.weights[0], bus.weights[1]);
        end
    endtask

    task automatic test_rounding_and_zero();
        load(4'd9, 4'd4);
        run_update(-4'sd1, 4'd1, 4'd3);          // -1>>>2=-1, -3>>>2=-1
        n_cmp++;
        if (bus.weights[0] !== 4'd8 || bus.weights[1] !== 4'd3) begin
            n_bad++; $display("FAIL floor_round: got %0d,%0d want 8,3", bus.weights[0], bus.weights[1]);
        end
        run_update(4'sd0, 4'd15, 4'd15);         // also checks done is reached
        n_cmp++;
        if (bus.weights[0] !== 4'd8 || bus.weights[1] !== 4'd3) begin
            n_bad++; $display("FAIL zero_error: got %0d,%0d want 8,3", bus.weights[0], bus.weights[1]);
        end
    endtask

    task automatic test_priority();
        bus.load_weights[0] = 4'd1;
        bus.load_weights[1] = 4'd2;
        bus.load_en = 1'b1;
        bus.error = 4'sd7;
        bus.inputs[0] = 4'd15;
        bus.inputs[1] = 4'd15;
        bus.start_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.start_ready !== 1'b0) begin
            n_bad++; $display("FAIL prio_ready: got %b want 0", bus.start_ready);
        end
        tick();
        bus.load_en = 1'b0;
        bus.start_valid = 1'b0;
        n_cmp++;
        if (bus.weights[0] !== 4'd1 || bus.weights[1] !== 4'd2 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL prio_load: w=%0d,%0d busy=%b want 1,2 0", bus.weights[0], bus.weights[1], bus.busy);
        end
        tick();
        tick();
        n_cmp++;
        if (bus.weights[0] !== 4'd1 || bus.weights[1] !== 4'd2 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL prio_no_update: w=%0d,%0d busy=%b want 1,2 0", bus.weights[0], bus.weights[1], bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        load(4'd4, 4'd4);
        bus.error = 4'sd4;
        bus.inputs[0] = 4'd4;
        bus.inputs[1] = 4'd4;                    // 16>>>2 = 4 -> 8,8
        bus.start_valid = 1'b1;
        tick();                                  // T: accepted
        bus.load_weights[0] = 4'd0;
        bus.load_weights[1] = 4'd0;
        bus.load_en = 1'b1;                      // must be ignored while busy
        n_cmp++;
        if (bus.start_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_ready_busy: got %b want 0", bus.start_ready);
        end
        tick();                                  // T+1
        tick();                                  // T+2, DONE
        bus.start_valid = 1'b0;
        bus.load_en = 1'b0;
        n_cmp++;
        if (bus.weights[0] !== 4'd8 || bus.weights[1] !== 4'd8 || bus.done !== 1'b1) begin
            n_bad++; $display("FAIL b2b_result: w=%0d,%0d done=%b want 8,8 1", bus.weights[0], bus.weights[1], bus.done);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (bus.weights[0] !== 4'd8 || bus.weights[1] !== 4'd8 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_not_queued: w=%0d,%0d busy=%b want 8,8 0", bus.weights[0], bus.weights[1], bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        load(4'd5, 4'd10);
        bus.error = 4'sd2;
        bus.inputs[0] = 4'd6;
        bus.inputs[1] = 4'd6;
        bus.start_valid = 1'b1;
        tick();                                  // T
        bus.start_valid = 1'b0;
        tick();                                  // T+1
        n_cmp++;
        if (bus.weights[0] !== 4'd8) begin
            n_bad++; $display("FAIL mid_partial: w0=%0d want 8", bus.weights[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (bus.done === 1'b1) saw_done = 1'b1;
        n_cmp++;
        if (bus.weights !== 8'h00 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_abort: w=%h busy=%b want 00 0", bus.weights, bus.busy);
        end
        tick();
        if (bus.done === 1'b1) saw_done = 1'b1;
        tick();
        if (bus.done === 1'b1) saw_done = 1'b1;
        n_cmp++;
        if (saw_done !== 1'b0 || bus.start_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_no_done: done_seen=%b ready=%b want 0 1", saw_done, bus.start_ready);
        end
        run_update(4'sd2, 4'd6, 4'd6);           // 0 + 3 on both
        n_cmp++;
        if (bus.weights[0] !== 4'd3 || bus.weights[1] !== 4'd3) begin
            n_bad++; $display("FAIL mid_recover: got %0d,%0d want 3,3", bus.weights[0], bus.weights[1]);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_update();
        test_saturation();
        test_rounding_and_zero();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/weight_updater.md
WEIGHT_UPDATER -- requirements
Module: weight_updater

Interface
REQ-001 Parameter num_inputs, default 2, number of weights held and updated.
REQ-002 Parameter bit_length, default 4, width of each weight and each input element.
REQ-003 Parameter lr_shift, default 2, learning-rate right-shift applied to each signed delta.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_en  input  1  request to overwrite all weights from load_weights.
REQ-007 load_weights  input  [num_inputs-1:0][bit_length-1:0]  unsigned initial weights.
REQ-008 start_valid  input  1  update-request valid.
REQ-009 start_ready  output  1  update-request ready.
REQ-010 error  input  signed [bit_length-1:0]  error term for this update.
REQ-011 inputs  input  [num_inputs-1:0][bit_length-1:0]  unsigned activations paired with the weights.
REQ-012 weights  output  [num_inputs-1:0][bit_length-1:0]  registered unsigned weight store, drives the weighted-sum stage.
REQ-013 busy  output  1  high while the FSM is not in IDLE.
REQ-014 done  output  1  single-cycle pulse on update completion.

Function
REQ-015 The FSM SHALL have three states: IDLE, UPDATE, DONE.
REQ-016 start_ready SHALL equal (state==IDLE) && !load_en && !rst.
REQ-017 Handshake: start_valid && start_ready at a rising edge SHALL capture error and inputs into internal registers, clear index to 0, and enter UPDATE.
REQ-018 UPDATE: each cycle, the weight at index SHALL be replaced by new_w; index increments; after index num_inputs-1 the FSM enters DONE.
REQ-019 Arithmetic: prod = error * input[i] as signed 2*bit_length+1 bits (input zero-extended); delta = prod >>> lr_shift (arithmetic, rounds toward minus infinity); sum = w[i] + delta at full width.
REQ-020 new_w SHALL saturate: sum<0 -> 0; sum>2^bit_length-1 -> 2^bit_length-1; otherwise sum.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 Latency: request accepted at edge T updates weights[i] at edge T+1+i; done is high during the cycle following edge T+num_inputs and start_ready returns in the cycle after that.
REQ-023 Only captured error and inputs SHALL be used; input changes after acceptance have no effect.
REQ-024 load_en in IDLE SHALL write load_weights into all weights at the next edge; load_en has priority over start_valid in the same cycle (start not accepted).
REQ-025 load_en outside IDLE SHALL be ignored.
REQ-026 start_valid outside IDLE SHALL be ignored (not queued).
REQ-027 error=0 SHALL leave all weights unchanged but still run the full UPDATE/DONE sequence.

Reset
REQ-028 During a cycle with rst high, at the next edge: weights=0, state=IDLE, index=0, done=0, captured registers=0.
REQ-029 Reset asserted mid-UPDATE SHALL abort; weights already written are also cleared to 0 and no done pulse is issued.
REQ-030 rst SHALL take priority over load_en and start_valid.

Structure
REQ-031 Shared package nn_pkg SHALL hold the FSM state enum (upd_state_t) and the saturation helper constants.
REQ-032 The per-weight combinational delta-and-saturate SHALL be one sub-module, weight_delta_sat (w, x, error -> new_w), instantiated once and time-shared by index.
REQ-033 weights SHALL be driven directly from flops, with no combinational path from inputs.

Verification (bit_length=4, lr_shift=2, num_inputs=2)
REQ-034 Reset then load_en with load_weights={5,10} -> weights={5,10} one edge later; busy=0, done=0.
REQ-035 From weights {5,10}, error=2, inputs={6,0} -> weights[0]=8 at T+1, weights[1]=10 at T+2, done pulse exactly one cycle.
REQ-036 From w=3, error=-3, input=5 (delta=-4) -> weight 0 (low saturation); from w=10, error=7, input=15 (delta=26) -> weight 15 (high saturation).
REQ-037 load_en and start_valid high together in IDLE -> load applied, start_ready=0, no UPDATE entered; start_valid held during UPDATE -> ignored.
REQ-038 rst asserted in the cycle after acceptance (mid-UPDATE) -> all weights 0, IDLE, no done pulse; a new request is accepted normally afterward.
